// File: rtl/muxn_rr.sv
// N-to-1 registered channel multiplexer with fixed-select and round-robin modes.
// One output register stage with a valid/ready handshake on both sides.
module muxn_rr #(
  parameter int unsigned N = 5,
  parameter int unsigned W = 8,
  localparam int unsigned SW = ($clog2(N) > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SW-1:0]  out_sel,
  output logic           sel_err
);

  localparam int unsigned NP = 1 << SW;

  logic [SW-1:0] ptr;
  logic          can_load_c;
  logic          gnt_vld_c;
  logic [SW-1:0] gnt_c;
  logic [W-1:0]  gnt_data_c;
  logic [NP-1:0] valid_pad_c;
  logic          sel_bad_c;

  assign can_load_c  = !out_valid || out_ready;
  assign valid_pad_c = NP'(in_valid);
  assign sel_bad_c   = !mode && (32'(sel) >= N);

  // Grant selection; the round-robin scan wraps modulo N starting at ptr.
  always_comb begin
    int unsigned idx;
    gnt_vld_c = 1'b0;
    gnt_c     = '0;
    idx       = 0;
    if (!mode) begin
      if (!sel_bad_c && valid_pad_c[sel]) begin
        gnt_vld_c = 1'b1;
        gnt_c     = sel;
      end
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        idx = 32'(ptr) + k;
        if (idx >= N) idx = idx - N;
        if (!gnt_vld_c && in_valid[idx]) begin
          gnt_vld_c = 1'b1;
          gnt_c     = SW'(idx);
        end
      end
    end
  end

  // Data mux and accept strobes for the granted channel.
  always_comb begin
    gnt_data_c = '0;
    in_ready   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt_c == SW'(i)) begin
        gnt_data_c  = in_data[i*W +: W];
        in_ready[i] = rst_n && can_load_c && gnt_vld_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
      ptr       <= '0;
    end else begin
      if (sel_bad_c) sel_err <= 1'b1;
      if (can_load_c) begin
        if (gnt_vld_c) begin
          out_data  <= gnt_data_c;
          out_sel   <= gnt_c;
          out_valid <= 1'b1;
          if (mode) ptr <= (32'(gnt_c) == N - 1) ? '0 : SW'(gnt_c + 1'b1);
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_muxn_rr.sv
// Directed bench for muxn_rr (N=5, W=8) with channel data 2,4,8,16,32.
module tb_muxn_rr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [2:0]  sel;
  logic [39:0] in_data;
  logic [4:0]  in_valid;
  logic [4:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_sel;
  logic        sel_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  muxn_rr #(.N(5), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sel(out_sel), .sel_err(sel_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mode = 1'b1; sel = 3'd0; in_valid = 5'b11111; out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b1; sel = 3'd0; in_valid = 5'b11111; out_ready = 1'b1;
    tick(); tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 8'd0) begin bad++; $display("FAIL reset_data got=%0d exp=0", out_data); end
    total++; if (out_sel !== 3'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", out_sel); end
    total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", sel_err); end
    total++; if (in_ready !== 5'b0) begin bad++; $display("FAIL reset_ready got=%b exp=00000", in_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_fixed();
    do_reset();
    mode = 1'b0; in_valid = 5'b11111; out_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      #1;
      total++;
      if (in_ready !== ((s < 5) ? 5'(1 << s) : 5'b0)) begin
        bad++; $display("FAIL fixed_ready sel=%0d got=%b", s, in_ready);
      end
      tick();
      total++;
      if (out_valid !== (s < 5)) begin bad++; $display("FAIL fixed_valid sel=%0d got=%b", s, out_valid); end
      total++;
      if (out_data !== ((s < 5) ? 8'(2 << s) : 8'd32)) begin
        bad++; $display("FAIL fixed_data sel=%0d got=%0d", s, out_data);
      end
      total++;
      if (out_sel !== ((s < 5) ? 3'(s) : 3'd4)) begin
        bad++; $display("FAIL fixed_sel sel=%0d got=%0d", s, out_sel);
      end
      total++;
      if (sel_err !== (s >= 5)) begin bad++; $display("FAIL fixed_err sel=%0d got=%b", s, sel_err); end
    end
    // Back in range, the sticky flag must stay set.
    sel = 3'd1;
    tick();
    total++; if (sel_err !== 1'b1) begin bad++; $display("FAIL fixed_err_sticky got=%b exp=1", sel_err); end
    total++; if (out_data !== 8'd4) begin bad++; $display("FAIL fixed_recover got=%0d exp=4", out_data); end
  endtask

  task automatic test_rr();
    int exp_seq [7] = '{0, 1, 2, 3, 4, 0, 1};
    do_reset();
    mode = 1'b1; in_valid = 5'b11111; out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #1;
      total++;
      if (in_ready !== 5'(1 << exp_seq[i])) begin
        bad++; $display("FAIL rr_ready step=%0d got=%b", i, in_ready);
      end
      tick();
      total++;
      if (out_sel !== 3'(exp_seq[i]) || out_valid !== 1'b1) begin
        bad++; $display("FAIL rr_sel step=%0d got=%0d exp=%0d v=%b", i, out_sel, exp_seq[i], out_valid);
      end
      total++;
      if (out_data !== 8'(2 << exp_seq[i])) begin
        bad++; $display("FAIL rr_data step=%0d got=%0d exp=%0d", i, out_data, 2 << exp_seq[i]);
      end
    end
  endtask

  task automatic test_rr_skip();
    int exp_seq [4] = '{1, 4, 1, 4};
    do_reset();
    mode = 1'b1; in_valid = 5'b10010; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (out_sel !== 3'(exp_seq[i]) || out_data !== 8'(2 << exp_seq[i])) begin
        bad++; $display("FAIL skip step=%0d got_sel=%0d exp_sel=%0d got_data=%0d", i, out_sel, exp_seq[i], out_data);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    mode = 1'b1; in_valid = 5'b11111; out_ready = 1'b1;
    tick(); tick(); tick();
    total++; if (out_data !== 8'd8) begin bad++; $display("FAIL stall_setup got=%0d exp=8", out_data); end
    out_ready = 1'b0;
    #1;
    total++; if (in_ready !== 5'b0) begin bad++; $display("FAIL stall_ready got=%b exp=00000", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (out_data !== 8'd8 || out_sel !== 3'd2 || out_valid !== 1'b1 || in_ready !== 5'b0) begin
        bad++; $display("FAIL stall_hold cyc=%0d data=%0d sel=%0d v=%b rdy=%b", i, out_data, out_sel, out_valid, in_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 5'b01000) begin bad++; $display("FAIL stall_release_ready got=%b exp=01000", in_ready); end
    tick();
    total++; if (out_data !== 8'd16 || out_sel !== 3'd3) begin bad++; $display("FAIL stall_release got=%0d exp=16", out_data); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mode = 1'b0; sel = 3'd7; in_valid = 5'b11111; out_ready = 1'b1;
    tick();
    total++; if (sel_err !== 1'b1) begin bad++; $display("FAIL mid_err_set got=%b exp=1", sel_err); end
    mode = 1'b1;
    tick(); tick();
    total++; if (out_valid !== 1'b1 || out_sel !== 3'd1) begin bad++; $display("FAIL mid_setup v=%b sel=%0d", out_valid, out_sel); end
    rst_n = 1'b0;
    #1;
    total++; if (in_ready !== 5'b0) begin bad++; $display("FAIL mid_ready got=%b exp=00000", in_ready); end
    tick();
    total++;
    if (out_valid !== 1'b0 || out_data !== 8'd0 || out_sel !== 3'd0 || sel_err !== 1'b0) begin
      bad++; $display("FAIL mid_clear v=%b data=%0d sel=%0d err=%b", out_valid, out_data, out_sel, sel_err);
    end
    rst_n = 1'b1;
    tick();
    total++; if (out_sel !== 3'd0 || out_data !== 8'd2) begin bad++; $display("FAIL mid_restart sel=%0d exp=0", out_sel); end
  endtask

  task automatic test_mode_switch();
    do_reset();
    mode = 1'b1; in_valid = 5'b11111; out_ready = 1'b1;
    tick(); tick();
    total++; if (out_sel !== 3'd1) begin bad++; $display("FAIL switch_setup got=%0d exp=1", out_sel); end
    mode = 1'b0; sel = 3'd3;
    tick();
    total++; if (out_data !== 8'd16 || out_sel !== 3'd3) begin bad++; $display("FAIL switch_fixed data=%0d sel=%0d", out_data, out_sel); end
    mode = 1'b1;
    tick();
    total++; if (out_sel !== 3'd2 || out_data !== 8'd8) begin bad++; $display("FAIL switch_resume sel=%0d exp=2", out_sel); end
  endtask

  task automatic test_no_grant();
    do_reset();
    mode = 1'b1; in_valid = 5'b00000; out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0 || in_ready !== 5'b0) begin bad++; $display("FAIL idle v=%b rdy=%b", out_valid, in_ready); end
    in_valid = 5'b00100;
    tick();
    total++; if (out_sel !== 3'd2 || out_valid !== 1'b1) begin bad++; $display("FAIL lone_grant sel=%0d exp=2", out_sel); end
    in_valid = 5'b00000;
    tick();
    total++; if (out_valid !== 1'b0 || out_sel !== 3'd2 || out_data !== 8'd8) begin bad++; $display("FAIL drop_hold v=%b sel=%0d", out_valid, out_sel); end
    in_valid = 5'b11111;
    tick();
    total++; if (out_sel !== 3'd3) begin bad++; $display("FAIL ptr_kept got=%0d exp=3", out_sel); end
  endtask

  initial begin
    in_data = {8'd32, 8'd16, 8'd8, 8'd4, 8'd2};
    rst_n = 1'b0; mode = 1'b0; sel = 3'd0; in_valid = 5'b0; out_ready = 1'b0;
    #2;
    test_reset();
    test_fixed();
    test_rr();
    test_rr_skip();
    test_stall();
    test_reset_mid();
    test_mode_switch();
    test_no_grant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muxn_rr.md
MUXN_RR -- requirements
Module: muxn_rr

Interface
REQ-001 Parameter N, default 5, number of input channels (legal 2..16).
REQ-002 Parameter W, default 8, data width per channel (legal 1..64).
REQ-003 Derived SW = max(1, ceil(log2 N)); SW is 3 for N=5.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 mode  in  1  0 = fixed select via sel; 1 = round-robin over valid channels.
REQ-007 sel  in  SW  channel index used in mode 0.
REQ-008 in_data  in  N*W  channel i at bits [i*W +: W].
REQ-009 in_valid  in  N  bit i = channel i offers a word.
REQ-010 in_ready  out  N  bit i = channel i word accepted this cycle; at most one bit set.
REQ-011 out_data  out  W  registered selected word.
REQ-012 out_valid  out  1  out_data/out_sel hold a valid word.
REQ-013 out_ready  in  1  downstream accepts the word this cycle.
REQ-014 out_sel  out  SW  channel index that produced out_data.
REQ-015 sel_err  out  1  sticky flag: out-of-range sel seen in mode 0.

Function
REQ-016 Load enable: can_load = !out_valid | out_ready.
REQ-017 Mode 0 grant: channel sel, only if sel < N and in_valid[sel]=1; otherwise no grant.
REQ-018 Mode 1 grant: first channel with in_valid=1 scanning ptr, ptr+1, ... N-1, 0, ... ptr-1; no grant if in_valid is all zero.
REQ-019 in_ready is combinational: in_ready[g]=1 only when can_load=1 and g is granted; all other bits 0.
REQ-020 Transfer (can_load & grant g): next edge out_data<=in_data[g], out_sel<=g, out_valid<=1; latency exactly 1 cycle.
REQ-021 can_load=1 and no grant: next edge out_valid<=0; out_data and out_sel keep previous values.
REQ-022 Stall (out_valid=1, out_ready=0): out_data, out_sel, out_valid held stable; in_ready all 0.
REQ-023 Throughput: one word per cycle while out_ready=1 and a grant exists.
REQ-024 ptr (internal, SW bits): reset 0; on each mode-1 transfer ptr<=g+1, wrapping N-1 -> 0; mode-0 transfers leave ptr unchanged.
REQ-025 mode and sel are sampled every cycle; a change affects only the next grant, never a held output word.
REQ-026 sel_err set on any cycle with mode=0 and sel >= N (regardless of in_valid); cleared only by reset.
REQ-027 in_valid deasserted on the granted channel in the same cycle: no transfer, no ptr change.
REQ-028 Arithmetic on ptr/index is modulo N, never modulo 2^SW.

Reset
REQ-029 rst_n=0 at a rising edge: out_data=0, out_sel=0, out_valid=0, sel_err=0, ptr=0.
REQ-030 While rst_n=0, in_ready is all 0 and no transfer occurs.
REQ-031 Reset mid-operation discards any held word without handshake; first cycle after release behaves as after power-up (mode 1 grants start search at channel 0).

Verification (N=5, W=8, in_data = 2,4,8,16,32 for ch0..4)
REQ-032 mode=0, all valid, out_ready=1, sel 0..7 stepped every 10 ns -> out_data 2,4,8,16,32 one cycle after each sel; sel 5..7 -> out_valid=0, sel_err=1 and stays 1.
REQ-033 mode=1, all valid, out_ready=1 -> out_sel 0,1,2,3,4,0,1; out_data 2,4,8,16,32,2,4; in_ready one-hot each cycle.
REQ-034 mode=1, in_valid=5'b10010 -> out_sel 1,4,1,4 (ptr wraps 4->0, skips invalid channels).
REQ-035 out_valid=1 with out_data=8, out_ready=0 for 3 cycles -> out_data stays 8, in_ready=0; out_ready=1 -> next word appears following edge.
REQ-036 rst_n=0 for one edge while out_valid=1 -> all outputs 0, sel_err 0; after release in mode 1 with all valid -> first out_sel=0.
REQ-037 mode 1->0 with sel=3 after out_sel=1 -> next out_data=16, out_sel=3; back to mode 1 -> grant resumes from ptr=2 (out_sel=2).
